aukv_memory: RTL and testbench
==============================

# aukv_memory

Memory-access stage of the AUK-V pipeline, sitting between execute and writeback. It consumes the execute stage's registered memory controls (address, store data, enable, write enable, load/store type, writeback selects). It runs one data-bus transaction per load or store using a req/ack handshake, with byte-lane alignment, load sign/zero extension and misalignment detection. It holds the pipeline through a stall request until the access completes, then registers the final writeback value, which also feeds execute's memory-stage forwarding input.

## Interface
- No parameters; XLEN fixed at 32.
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_stall  in  1  downstream hold; freezes writeback outputs
- i_flush  in  1  kills the instruction entering/completing this cycle
- i_mem_en, i_mem_we  in  1,1  access request / store
- i_mem_addr  in  32  byte address
- i_mem_wr_data  in  32  store data (already forwarded)
- i_load_type  in  3  0=LB 1=LH 2=LW 4=LBU 5=LHU
- i_store_type  in  2  0=SB 1=SH 2=SW
- i_exe_res  in  32  execute result
- i_wb_data_sel  in  1  1=load data, 0=i_exe_res
- i_wb_reg_sel  in  5  destination register
- i_wb_we, i_instr_valid, i_illegal  in  1 each  pass-through controls
- i_pc  in  32  instruction PC
- o_dbus_req  out  1  bus request
- o_dbus_we  out  1  bus write
- o_dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dbus_be  out  4  byte enables
- o_dbus_wdata  out  32  lane-replicated store data
- i_dbus_ack  in  1  transaction complete; i_dbus_rdata valid
- i_dbus_rdata  in  32  read word
- o_stall_req  out  1  to hazard unit: hold execute and earlier
- o_wb_data  out  32  final writeback value / me-forward value
- o_wb_reg_sel  out  5; o_wb_we  out  1; o_pc  out  32; o_instr_valid, o_illegal  out  1 each
- o_misaligned  out  1  registered misaligned-access flag

## Operation
- FSM states IDLE, BUSY, HOLD; reset → IDLE.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]≠0. Issues no bus access and does not stall. Registers o_misaligned=1 and o_wb_we=0.
- IDLE, no access (i_mem_en=0 or misaligned): when ~i_stall, register pass-through. o_wb_data = i_exe_res. o_wb_we = i_wb_we & ~i_flush.
- IDLE, valid access, ~i_flush, ~i_stall: latch addr/be/wdata/we, type, byte offset, reg_sel, pc and controls. Set o_dbus_req=1 and go to BUSY. Writeback regs keep their old values and o_wb_we ← 0.
- BUSY: bus outputs held stable until ack. On i_dbus_ack: o_dbus_req ← 0.
  - If ~i_stall: write writeback regs, go to IDLE.
  - Else: capture the formed result in a holding register and go to HOLD.
- HOLD: when ~i_stall, write the held result to the writeback regs and go to IDLE.
- Byte enables: SB → 0001<<addr[1:0]. SH → 0011<<{addr[1],0}. SW → 1111.
- Store wdata: SB → {4{d[7:0]}}, SH → {2{d[15:0]}}, SW → d.
- Load extraction: byte/halfword selected by the latched offset. LB/LH sign-extend, LBU/LHU zero-extend.
- Store completion writes o_wb_we = latched i_wb_we (normally 0).
- i_flush during BUSY/HOLD:
  - The bus transaction is never withdrawn; req stays high until ack.
  - A sticky kill flag forces o_wb_we=0 and o_instr_valid=0 on completion.
- Undefined load_type (3,6,7) behaves as LW; store_type 3 behaves as SW.

## Timing
- Reset values: every output is 0, state = IDLE, kill flag = 0.
- Non-memory instruction: 1-cycle latency, no stall.
- Memory access: o_stall_req is combinational.
  - Asserted in IDLE with a valid access.
  - Asserted in BUSY while ~i_dbus_ack.
  - Asserted in BUSY when i_dbus_ack & i_stall.
  - Asserted throughout HOLD.
- Execute therefore advances on the ack edge. Minimum access is 2 cycles: request cycle plus ack in the first BUSY cycle.
- While o_dbus_req=1, addr/be/wdata/we are constant. req drops in the cycle after ack.
- Reset mid-transaction: req drops immediately (asynchronous) and the access is abandoned.

## Structure
- Shared package aukv_pkg holds the load/store type encodings and the FSM state constants.
- One natural sub-module: aukv_lsu_align, combinational. It computes be and wdata from store_type/addr, and extends rdata from load_type/offset. It is shared with any future cache path.

## Test plan
- LB addr 0x1003, rdata 0x80FF_0000, ack in first BUSY cycle → o_wb_data 0xFFFF_FF80. Same access as LBU → 0x0000_0080. 2 cycles each.
- SH addr 0x2002, data 0x1234_ABCD → be 4'b1100, wdata 0xABCD_ABCD, dbus_addr 0x2000, o_wb_we 0.
- LW addr 0x1001 → no o_dbus_req, o_stall_req 0, o_misaligned 1, o_wb_we 0.
- Ack delayed 3 cycles → o_dbus_req high 4 cycles with bus fields unchanged. o_stall_req high 4 cycles, drops in the ack cycle.
- Ack while i_stall=1 for 2 cycles → HOLD. LW rdata 0xDEAD_BEEF appears on o_wb_data the cycle after i_stall drops.
- i_flush in BUSY, then ack → o_wb_we 0. i_rstn low mid-BUSY → o_dbus_req 0 immediately, all outputs 0.

Source files
------------

// File: rtl/aukv_pkg.sv
// Shared AUK-V memory-stage definitions: load/store type encodings, access
// sizing helpers and the memory-stage FSM states.
package aukv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  localparam logic [1:0] ST_SB = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SW = 2'd2;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} mem_state_e;

  // Undefined encodings fall through to word accesses.
  function automatic acc_size_e acc_size(input logic we, input logic [2:0] lt,
                                         input logic [1:0] st);
    acc_size_e sz;
    if (we) begin
      case (st)
        ST_SB:   sz = SZ_BYTE;
        ST_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (lt)
        LD_LB, LD_LBU: sz = SZ_BYTE;
        LD_LH, LD_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aukv_lsu_align.sv
// Combinational byte-lane alignment: store byte enables / lane replication
// and load byte/halfword extraction with sign or zero extension.
module aukv_lsu_align
  import aukv_pkg::*;
(
  input  logic [1:0]      i_store_type,
  input  logic [1:0]      i_st_off,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [2:0]      i_load_type,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    case (i_store_type)
      ST_SB: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_wr_data[7:0]}};
      end
      ST_SH: begin
        o_be    = 4'b0011 << {i_st_off[1], 1'b0};
        o_wdata = {2{i_wr_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wr_data;
      end
    endcase
  end

  always_comb begin
    byte_s = i_rdata[{i_ld_off, 3'b000} +: 8];
    half_s = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
    case (i_load_type)
      LD_LB:   o_ld_data = {{24{byte_s[7]}}, byte_s};
      LD_LH:   o_ld_data = {{16{half_s[15]}}, half_s};
      LD_LBU:  o_ld_data = {24'd0, byte_s};
      LD_LHU:  o_ld_data = {16'd0, half_s};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/aukv_memory.sv
// AUK-V memory-access stage: one req/ack data-bus transaction per load/store,
// stalls upstream until completion, then registers the writeback value.
module aukv_memory
  import aukv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_mem_en,
  input  logic            i_mem_we,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_mem_wr_data,
  input  logic [2:0]      i_load_type,
  input  logic [1:0]      i_store_type,
  input  logic [XLEN-1:0] i_exe_res,
  input  logic            i_wb_data_sel,
  input  logic [4:0]      i_wb_reg_sel,
  input  logic            i_wb_we,
  input  logic            i_instr_valid,
  input  logic            i_illegal,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_dbus_req,
  output logic            o_dbus_we,
  output logic [XLEN-1:0] o_dbus_addr,
  output logic [3:0]      o_dbus_be,
  output logic [XLEN-1:0] o_dbus_wdata,
  input  logic            i_dbus_ack,
  input  logic [XLEN-1:0] i_dbus_rdata,
  output logic            o_stall_req,
  output logic [XLEN-1:0] o_wb_data,
  output logic [4:0]      o_wb_reg_sel,
  output logic            o_wb_we,
  output logic [XLEN-1:0] o_pc,
  output logic            o_instr_valid,
  output logic            o_illegal,
  output logic            o_misaligned
);

  mem_state_e      state_q, state_d;
  logic            dbus_req_q, dbus_req_d, dbus_we_q, dbus_we_d;
  logic [XLEN-1:0] dbus_addr_q, dbus_addr_d, dbus_wdata_q, dbus_wdata_d;
  logic [3:0]      dbus_be_q, dbus_be_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d, pc_q, pc_d;
  logic [4:0]      wb_reg_sel_q, wb_reg_sel_d;
  logic            wb_we_q, wb_we_d, instr_valid_q, instr_valid_d;
  logic            illegal_q, illegal_d, misaligned_q, misaligned_d;
  logic            kill_q, kill_d, acc_we_q, acc_we_d, acc_valid_q, acc_valid_d;
  // Per-access payload; no reset needed, only read after being latched.
  logic [2:0]      ld_type_q, ld_type_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            wb_sel_q, wb_sel_d, acc_illegal_q, acc_illegal_d;
  logic [XLEN-1:0] exe_res_q, exe_res_d, acc_pc_q, acc_pc_d, hold_data_q, hold_data_d;
  logic [4:0]      acc_reg_sel_q, acc_reg_sel_d;

  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, ld_data, result;
  logic            mis_acc, valid_acc, kill_now;

  aukv_lsu_align u_align (
    .i_store_type (i_store_type),
    .i_st_off     (i_mem_addr[1:0]),
    .i_wr_data    (i_mem_wr_data),
    .i_load_type  (ld_type_q),
    .i_ld_off     (ld_off_q),
    .i_rdata      (i_dbus_rdata),
    .o_be         (st_be),
    .o_wdata      (st_wdata),
    .o_ld_data    (ld_data)
  );

  assign mis_acc   = i_mem_en & is_misaligned(acc_size(i_mem_we, i_load_type, i_store_type),
                                              i_mem_addr[1:0]);
  assign valid_acc = i_mem_en & ~mis_acc;
  assign kill_now  = kill_q | i_flush;
  assign result    = wb_sel_q ? ld_data : exe_res_q;

  always_comb begin
    o_stall_req = 1'b0;
    case (state_q)
      IDLE:    o_stall_req = valid_acc & ~i_flush;
      BUSY:    o_stall_req = ~i_dbus_ack | i_stall;
      HOLD:    o_stall_req = 1'b1;
      default: o_stall_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dbus_req_d = dbus_req_q;     dbus_we_d = dbus_we_q;
    dbus_addr_d = dbus_addr_q;   dbus_be_d = dbus_be_q;     dbus_wdata_d = dbus_wdata_q;
    wb_data_d = wb_data_q;       wb_reg_sel_d = wb_reg_sel_q; wb_we_d = wb_we_q;
    pc_d = pc_q;                 instr_valid_d = instr_valid_q;
    illegal_d = illegal_q;       misaligned_d = misaligned_q;
    kill_d = kill_q;             acc_we_d = acc_we_q;       acc_valid_d = acc_valid_q;
    ld_type_d = ld_type_q;       ld_off_d = ld_off_q;       wb_sel_d = wb_sel_q;
    acc_illegal_d = acc_illegal_q; exe_res_d = exe_res_q;   acc_pc_d = acc_pc_q;
    hold_data_d = hold_data_q;   acc_reg_sel_d = acc_reg_sel_q;
    case (state_q)
      IDLE: if (!i_stall) begin
        if (valid_acc && !i_flush) begin
          dbus_req_d    = 1'b1;
          dbus_we_d     = i_mem_we;
          dbus_addr_d   = {i_mem_addr[XLEN-1:2], 2'b00};
          dbus_be_d     = st_be;
          dbus_wdata_d  = st_wdata;
          ld_type_d     = i_load_type;
          ld_off_d      = i_mem_addr[1:0];
          wb_sel_d      = i_wb_data_sel;
          exe_res_d     = i_exe_res;
          acc_reg_sel_d = i_wb_reg_sel;
          acc_pc_d      = i_pc;
          acc_we_d      = i_wb_we;
          acc_valid_d   = i_instr_valid;
          acc_illegal_d = i_illegal;
          kill_d        = 1'b0;
          wb_we_d       = 1'b0;
          misaligned_d  = 1'b0;
          state_d       = BUSY;
        end else begin
          wb_data_d     = i_exe_res;
          wb_reg_sel_d  = i_wb_reg_sel;
          wb_we_d       = i_wb_we & ~i_flush & ~mis_acc;
          pc_d          = i_pc;
          instr_valid_d = i_instr_valid & ~i_flush;
          illegal_d     = i_illegal;
          misaligned_d  = mis_acc & ~i_flush;
        end
      end
      BUSY: begin
        kill_d = kill_now;
        if (i_dbus_ack) begin
          dbus_req_d = 1'b0;
          if (!i_stall) begin
            wb_data_d = result;
            state_d   = IDLE;
          end else begin
            hold_data_d = result;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        kill_d = kill_now;
        if (!i_stall) begin
          wb_data_d = hold_data_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Common completion bookkeeping for both BUSY->IDLE and HOLD->IDLE.
    if (state_q != IDLE && state_d == IDLE) begin
      wb_reg_sel_d  = acc_reg_sel_q;
      wb_we_d       = acc_we_q & ~kill_now;
      pc_d          = acc_pc_q;
      instr_valid_d = acc_valid_q & ~kill_now;
      illegal_d     = acc_illegal_q;
      misaligned_d  = 1'b0;
      kill_d        = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      dbus_req_q <= 1'b0;  dbus_we_q <= 1'b0;  dbus_addr_q <= '0;
      dbus_be_q <= '0;     dbus_wdata_q <= '0;
      wb_data_q <= '0;     wb_reg_sel_q <= '0; wb_we_q <= 1'b0;
      pc_q <= '0;          instr_valid_q <= 1'b0;
      illegal_q <= 1'b0;   misaligned_q <= 1'b0;
      kill_q <= 1'b0;      acc_we_q <= 1'b0;   acc_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dbus_req_q <= dbus_req_d;  dbus_we_q <= dbus_we_d;  dbus_addr_q <= dbus_addr_d;
      dbus_be_q <= dbus_be_d;    dbus_wdata_q <= dbus_wdata_d;
      wb_data_q <= wb_data_d;    wb_reg_sel_q <= wb_reg_sel_d; wb_we_q <= wb_we_d;
      pc_q <= pc_d;              instr_valid_q <= instr_valid_d;
      illegal_q <= illegal_d;    misaligned_q <= misaligned_d;
      kill_q <= kill_d;          acc_we_q <= acc_we_d;     acc_valid_q <= acc_valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    ld_type_q <= ld_type_d;         ld_off_q <= ld_off_d;     wb_sel_q <= wb_sel_d;
    acc_illegal_q <= acc_illegal_d; exe_res_q <= exe_res_d;   acc_pc_q <= acc_pc_d;
    hold_data_q <= hold_data_d;     acc_reg_sel_q <= acc_reg_sel_d;
  end

  assign o_dbus_req    = dbus_req_q;
  assign o_dbus_we     = dbus_we_q;
  assign o_dbus_addr   = dbus_addr_q;
  assign o_dbus_be     = dbus_be_q;
  assign o_dbus_wdata  = dbus_wdata_q;
  assign o_wb_data     = wb_data_q;
  assign o_wb_reg_sel  = wb_reg_sel_q;
  assign o_wb_we       = wb_we_q;
  assign o_pc          = pc_q;
  assign o_instr_valid = instr_valid_q;
  assign o_illegal     = illegal_q;
  assign o_misaligned  = misaligned_q;

endmodule

// File: tb/tb_aukv_memory.sv
// Directed self-checking bench for the AUK-V memory-access stage.
module tb_aukv_memory;

  logic        clk = 1'b0;
  logic        rstn, stall, flush, mem_en, mem_we, wb_data_sel, wb_we, instr_valid, illegal;
  logic [31:0] mem_addr, mem_wr_data, exe_res, pc, dbus_rdata;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [4:0]  wb_reg_sel;
  logic        dbus_ack;
  logic        dbus_req, dbus_we, stall_req, o_wb_we, o_instr_valid, o_illegal, misaligned;
  logic [31:0] dbus_addr, dbus_wdata, wb_data, o_pc;
  logic [3:0]  dbus_be;
  logic [4:0]  o_wb_reg_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aukv_memory dut (
    .i_clk(clk), .i_rstn(rstn), .i_stall(stall), .i_flush(flush),
    .i_mem_en(mem_en), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
    .i_mem_wr_data(mem_wr_data), .i_load_type(load_type), .i_store_type(store_type),
    .i_exe_res(exe_res), .i_wb_data_sel(wb_data_sel), .i_wb_reg_sel(wb_reg_sel),
    .i_wb_we(wb_we), .i_instr_valid(instr_valid), .i_illegal(illegal), .i_pc(pc),
    .o_dbus_req(dbus_req), .o_dbus_we(dbus_we), .o_dbus_addr(dbus_addr),
    .o_dbus_be(dbus_be), .o_dbus_wdata(dbus_wdata), .i_dbus_ack(dbus_ack),
    .i_dbus_rdata(dbus_rdata), .o_stall_req(stall_req), .o_wb_data(wb_data),
    .o_wb_reg_sel(o_wb_reg_sel), .o_wb_we(o_wb_we), .o_pc(o_pc),
    .o_instr_valid(o_instr_valid), .o_illegal(o_illegal), .o_misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    stall = 0; flush = 0; mem_en = 0; mem_we = 0; mem_addr = 0; mem_wr_data = 0;
    load_type = 0; store_type = 0; exe_res = 0; wb_data_sel = 0; wb_reg_sel = 0;
    wb_we = 0; instr_valid = 0; illegal = 0; pc = 0; dbus_ack = 0; dbus_rdata = 0;
  endtask

  task automatic set_acc(input logic we, input logic [31:0] addr, input logic [2:0] lt,
                         input logic [1:0] st, input logic [31:0] wd);
    mem_en = 1; mem_we = we; mem_addr = addr; load_type = lt; store_type = st;
    mem_wr_data = wd; wb_data_sel = ~we; wb_we = ~we; wb_reg_sel = 5'd7;
    instr_valid = 1; pc = 32'h0000_0100; exe_res = 32'h0000_0055;
  endtask

  // Load with ack in the first BUSY cycle.
  task automatic quick_load(input string tag, input logic [31:0] addr, input logic [2:0] lt,
                            input logic [31:0] rdata, input logic [31:0] exp);
    set_acc(1'b0, addr, lt, 2'd0, 32'd0);
    #1 chk({tag, "_stall_idle"}, {31'd0, stall_req}, 32'd1);
    tick;
    chk({tag, "_req"}, {31'd0, dbus_req}, 32'd1);
    chk({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
    dbus_ack = 1; dbus_rdata = rdata;
    #1 chk({tag, "_stall_ack"}, {31'd0, stall_req}, 32'd0);
    tick;
    clear_in;
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_wbwe"}, {31'd0, o_wb_we}, 32'd1);
    chk({tag, "_req_drop"}, {31'd0, dbus_req}, 32'd0);
  endtask

  initial begin
    rstn = 0;
    clear_in;
    tick; tick;
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_misal", {31'd0, misaligned}, 32'd0);
    rstn = 1;
    tick;

    // Non-memory pass-through, one cycle.
    exe_res = 32'hCAFE_0001; wb_we = 1; wb_reg_sel = 5'd3; instr_valid = 1; pc = 32'h40;
    #1 chk("alu_stall", {31'd0, stall_req}, 32'd0);
    tick;
    chk("alu_data", wb_data, 32'hCAFE_0001);
    chk("alu_wbwe", {31'd0, o_wb_we}, 32'd1);
    chk("alu_reg", {27'd0, o_wb_reg_sel}, 32'd3);
    chk("alu_pc", o_pc, 32'h40);
    flush = 1;
    tick;
    chk("alu_flush_wbwe", {31'd0, o_wb_we}, 32'd0);
    clear_in;

    quick_load("lb", 32'h0000_1003, 3'd0, 32'h80FF_0000, 32'hFFFF_FF80);
    quick_load("lbu", 32'h0000_1003, 3'd4, 32'h80FF_0000, 32'h0000_0080);
    quick_load("lh", 32'h0000_1002, 3'd1, 32'h8001_0000, 32'hFFFF_8001);
    quick_load("lhu", 32'h0000_1002, 3'd5, 32'h8001_0000, 32'h0000_8001);

    // SH at 0x2002.
    set_acc(1'b1, 32'h0000_2002, 3'd0, 2'd1, 32'h1234_ABCD);
    tick;
    chk("sh_be", {28'd0, dbus_be}, 32'h0000_000C);
    chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dbus_addr, 32'h0000_2000);
    chk("sh_we", {31'd0, dbus_we}, 32'd1);
    dbus_ack = 1;
    tick;
    clear_in;
    chk("sh_wbwe", {31'd0, o_wb_we}, 32'd0);

    // SB at 0x3001.
    set_acc(1'b1, 32'h0000_3001, 3'd0, 2'd0, 32'h0000_00A5);
    tick;
    chk("sb_be", {28'd0, dbus_be}, 32'h0000_0002);
    chk("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
    dbus_ack = 1;
    tick;
    clear_in;

    // Misaligned LW.
    set_acc(1'b0, 32'h0000_1001, 3'd2, 2'd0, 32'd0);
    #1 chk("mis_stall", {31'd0, stall_req}, 32'd0);
    tick;
    clear_in;
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_wbwe", {31'd0, o_wb_we}, 32'd0);
    chk("mis_req", {31'd0, dbus_req}, 32'd0);
    chk("mis_data", wb_data, 32'h0000_0055);

    // Ack delayed 3 cycles.
    set_acc(1'b0, 32'h0000_3000, 3'd2, 2'd0, 32'd0);
    #1 chk("dly_stall0", {31'd0, stall_req}, 32'd1);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("dly_req", {31'd0, dbus_req}, 32'd1);
      chk("dly_addr", dbus_addr, 32'h0000_3000);
      chk("dly_stall", {31'd0, stall_req}, 32'd1);
      tick;
    end
    dbus_ack = 1; dbus_rdata = 32'h0BAD_F00D;
    #1;
    chk("dly_req_ack", {31'd0, dbus_req}, 32'd1);
    chk("dly_stall_ack", {31'd0, stall_req}, 32'd0);
    tick;
    clear_in;
    chk("dly_req_drop", {31'd0, dbus_req}, 32'd0);
    chk("dly_data", wb_data, 32'h0BAD_F00D);

    // Ack under downstream stall -> HOLD.
    set_acc(1'b0, 32'h0000_4000, 3'd2, 2'd0, 32'd0);
    tick;
    dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF; stall = 1;
    #1 chk("hold_stall_ack", {31'd0, stall_req}, 32'd1);
    tick;
    dbus_ack = 0;
    chk("hold_req", {31'd0, dbus_req}, 32'd0);
    chk("hold_frozen", wb_data, 32'h0BAD_F00D);
    chk("hold_stall1", {31'd0, stall_req}, 32'd1);
    tick;
    stall = 0;
    #1 chk("hold_stall2", {31'd0, stall_req}, 32'd1);
    tick;
    clear_in;
    chk("hold_data", wb_data, 32'hDEAD_BEEF);
    chk("hold_wbwe", {31'd0, o_wb_we}, 32'd1);

    // Flush while BUSY.
    set_acc(1'b0, 32'h0000_5000, 3'd2, 2'd0, 32'd0);
    tick;
    flush = 1;
    tick;
    flush = 0;
    chk("fl_req", {31'd0, dbus_req}, 32'd1);
    dbus_ack = 1; dbus_rdata = 32'h1122_3344;
    tick;
    clear_in;
    chk("fl_wbwe", {31'd0, o_wb_we}, 32'd0);
    chk("fl_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("fl_req_drop", {31'd0, dbus_req}, 32'd0);

    // Asynchronous reset mid-BUSY.
    set_acc(1'b0, 32'h0000_6000, 3'd2, 2'd0, 32'd0);
    tick;
    chk("ar_req_pre", {31'd0, dbus_req}, 32'd1);
    #2 rstn = 0;
    #1;
    chk("ar_req", {31'd0, dbus_req}, 32'd0);
    chk("ar_addr", dbus_addr, 32'd0);
    chk("ar_wb_data", wb_data, 32'd0);
    clear_in;
    tick;
    rstn = 1;
    tick;
    chk("ar_stall", {31'd0, stall_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
